// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch port.
package imem_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10
   } fault_e;

   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_resp_queue.sv
// Two-entry in-order response FIFO; head data is combinational from storage.
module imem_resp_queue
   import imem_pkg::*;
#(
   parameter int W = 66
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [W-1:0] ent_q [2];
   logic [W-1:0] ent_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   // next-state for pointers, count and storage
   always_comb begin
      ent_d    = ent_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      if (clr) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            ent_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         ent_q    <= ent_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = ent_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/imem_fetch_port.sv
// IF-stage instruction memory with request/response handshakes, 1-cycle read and 2-entry response queue.
// Optional macro IMEM_WRITE_PORT_EN adds a byte-strobed program-load write port.
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int    XLEN      = 32,
   parameter int    DEPTH     = 1024,
   parameter string INIT_FILE = "imem.hex"
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_pc,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_instr,
   output logic [XLEN-1:0] resp_pc,
   output logic [1:0]      resp_fault
`ifdef IMEM_WRITE_PORT_EN
   ,
   input  logic              wr_en,
   input  logic [XLEN-1:0]   wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic [XLEN/8-1:0] wr_strb
`endif
);

   localparam int IDXW = idx_width(DEPTH);
   localparam int QW   = 2 * XLEN + 2;

   logic [XLEN-1:0] mem_q [DEPTH];

   logic            infl_valid_q, infl_valid_d;
   logic [XLEN-1:0] infl_pc_q, infl_pc_d;
   fault_e          infl_fault_q, infl_fault_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [XLEN-1:0] infl_instr;

   logic [IDXW-1:0] req_idx;
   fault_e          req_fault;
   logic [2:0]      occ;
   logic            any_valid, pop, accept, q_push, q_pop;
   logic [QW-1:0]   q_head;
   logic [1:0]      q_count;

   // request decode: word index and fault classification (misalign wins)
   always_comb begin
      req_idx = req_pc[IDXW+1:2];
      if (req_pc[1:0] != 2'b00) begin
         req_fault = FAULT_MISALIGN;
      end else if ((req_pc >> (IDXW + 2)) != '0) begin
         req_fault = FAULT_RANGE;
      end else begin
         req_fault = FAULT_NONE;
      end
   end

   // handshake and queue control; the in-flight word always leaves its stage after one cycle
   always_comb begin
      occ       = {1'b0, q_count} + {2'b00, infl_valid_q};
      any_valid = (q_count != 2'd0) || infl_valid_q;
      pop       = !rst && any_valid && resp_ready;
      req_ready = !rst && ((occ - {2'b00, pop}) < 3'd2);
      accept    = req_valid && req_ready;
      q_push    = infl_valid_q && !((q_count == 2'd0) && pop);
      q_pop     = pop && (q_count != 2'd0);
   end

   // in-flight stage next state; a request taken during a flush survives it
   always_comb begin
      infl_valid_d = accept;
      if (accept) begin
         infl_pc_d    = req_pc;
         infl_fault_d = req_fault;
         rdata_d      = mem_q[req_idx];
      end else begin
         infl_pc_d    = infl_pc_q;
         infl_fault_d = infl_fault_q;
         rdata_d      = rdata_q;
      end
   end

   // in-flight stage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         infl_valid_q <= 1'b0;
         infl_pc_q    <= '0;
         infl_fault_q <= FAULT_NONE;
         rdata_q      <= '0;
      end else begin
         infl_valid_q <= infl_valid_d;
         infl_pc_q    <= infl_pc_d;
         infl_fault_q <= infl_fault_d;
         rdata_q      <= rdata_d;
      end
   end

   assign infl_instr = (infl_fault_q != FAULT_NONE) ? XLEN'(NOP_INSTR) : rdata_q;

   imem_resp_queue #(.W(QW)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (q_push),
      .push_data ({infl_pc_q, infl_instr, infl_fault_q}),
      .pop       (q_pop),
      .head_data (q_head),
      .count     (q_count)
   );

   // response mux: queue head first, else bypass the in-flight word
   always_comb begin
      if (rst) begin
         resp_valid = 1'b0;
         resp_pc    = '0;
         resp_instr = '0;
         resp_fault = FAULT_NONE;
      end else if (q_count != 2'd0) begin
         resp_valid = 1'b1;
         resp_pc    = q_head[QW-1 -: XLEN];
         resp_instr = q_head[XLEN+1 -: XLEN];
         resp_fault = q_head[1:0];
      end else if (infl_valid_q) begin
         resp_valid = 1'b1;
         resp_pc    = infl_pc_q;
         resp_instr = infl_instr;
         resp_fault = infl_fault_q;
      end else begin
         resp_valid = 1'b0;
         resp_pc    = '0;
         resp_instr = '0;
         resp_fault = FAULT_NONE;
      end
   end

`ifdef IMEM_WRITE_PORT_EN
   logic [IDXW-1:0] wr_idx;
   logic            wr_ok;

   // write address decode; misaligned or out-of-range writes are dropped
   always_comb begin
      wr_idx = wr_addr[IDXW+1:2];
      if (wr_en && (wr_addr[1:0] == 2'b00) && ((wr_addr >> (IDXW + 2)) == '0)) begin
         wr_ok = 1'b1;
      end else begin
         wr_ok = 1'b0;
      end
   end

   // byte-lane write; same-edge reads see the old word
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int b = 0; b < XLEN / 8; b++) begin
            if (wr_strb[b]) begin
               mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: vector table plus directed stall/flush/reset/write sequences.
module tb_imem_fetch_port;
   import imem_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready;
   logic [31:0] req_pc, resp_instr, resp_pc;
   logic [1:0]  resp_fault;
`ifdef IMEM_WRITE_PORT_EN
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
`endif

   always #5 clk = ~clk;

   imem_fetch_port #(.XLEN(32), .DEPTH(DEPTH), .INIT_FILE("")) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_pc    (resp_pc),
      .resp_fault (resp_fault)
`ifdef IMEM_WRITE_PORT_EN
      ,
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_strb    (wr_strb)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  fault;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  fault;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] img [DEPTH];
   vec_t        vecs [9];
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one request until accepted (bounded) and push its expected response.
   task automatic fetch_chk(input logic [31:0] pc, input logic [1:0] f);
      exp_t e;
      int   n;
      req_valid = 1'b1;
      req_pc    = pc;
      n         = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL accept_timeout: pc %h not accepted, want accept within 50 cycles", pc);
      end else begin
         e.pc    = pc;
         e.fault = f;
         e.instr = (f != 2'b00) ? NOP_INSTR : img[pc[11:2]];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      resp_ready = 1'b1;
      for (int n = 0; n < 50 && sb.size() != 0; n++) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
      end
   endtask

   // Response monitor: compare every delivered word against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_resp: got pc %h, want no response", resp_pc);
         end else begin
            mon_e = sb.pop_front();
            check("resp_pc", resp_pc, mon_e.pc);
            check("resp_instr", resp_instr, mon_e.instr);
            check("resp_fault", {30'd0, resp_fault}, {30'd0, mon_e.fault});
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = 32'd0; resp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) img[i] = 32'h1000_0000 + (i * 32'h0001_0011);
      vecs[0] = '{32'h0000_0000, 2'b00};
      vecs[1] = '{32'h0000_0004, 2'b00};
      vecs[2] = '{32'h0000_0008, 2'b00};
      vecs[3] = '{32'h0000_0006, 2'b01};
      vecs[4] = '{32'h0000_1000, 2'b10};
      vecs[5] = '{32'h0000_1002, 2'b01};
      vecs[6] = '{32'h0000_003C, 2'b00};
      vecs[7] = '{32'h0000_0FFC, 2'b00};
      vecs[8] = '{32'h8000_0000, 2'b10};
`ifdef IMEM_WRITE_PORT_EN
      wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_strb = 4'h0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = i * 4; wr_data = img[i]; wr_strb = 4'hF;
         step();
      end
      wr_en = 1'b0;
`else
      for (int i = 0; i < DEPTH; i++) dut.mem_q[i] = img[i];
`endif
      step();
      step();
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_instr", resp_instr, 32'd0);
      check("rst_resp_pc", resp_pc, 32'd0);
      check("rst_resp_fault", {30'd0, resp_fault}, 32'd0);
      rst = 1'b0;
      step();

      // latency 1 and back-to-back table
      resp_ready = 1'b1;
      fetch_chk(32'h0, 2'b00);
      check("lat1_valid", {31'd0, resp_valid}, 32'd1);
      check("lat1_pc", resp_pc, 32'h0);
      for (int i = 0; i < 9; i++) fetch_chk(vecs[i].pc, vecs[i].fault);
      check("b2b_last_pc", resp_pc, 32'h8000_0000);
      drain();

      // stall: two accepted, third blocked until the consumer pops
      resp_ready = 1'b0;
      fetch_chk(32'h10, 2'b00);
      fetch_chk(32'h14, 2'b00);
      req_valid = 1'b1; req_pc = 32'h18;
      #1;
      check("full_ready", {31'd0, req_ready}, 32'd0);
      check("stall_pc", resp_pc, 32'h10);
      step();
      check("full_ready2", {31'd0, req_ready}, 32'd0);
      check("stable_pc", resp_pc, 32'h10);
      check("stable_instr", resp_instr, img[4]);
      resp_ready = 1'b1;
      #1;
      check("pop_ready", {31'd0, req_ready}, 32'd1);
      fetch_chk(32'h18, 2'b00);
      drain();

      // flush with full queue: request waits, queued words vanish
      resp_ready = 1'b0;
      fetch_chk(32'h20, 2'b00);
      fetch_chk(32'h24, 2'b00);
      step();
      flush = 1'b1; req_valid = 1'b1; req_pc = 32'h40;
      sb.delete();
      @(negedge clk);
      check("flush_full_ready", {31'd0, req_ready}, 32'd0);
      step();
      flush = 1'b0;
      check("post_flush_valid", {31'd0, resp_valid}, 32'd0);
      fetch_chk(32'h40, 2'b00);
      check("redirect_pc", resp_pc, 32'h40);
      drain();

      // flush with a request taken in the flush cycle
      resp_ready = 1'b0;
      fetch_chk(32'h28, 2'b00);
      flush = 1'b1;
      sb.delete();
      fetch_chk(32'h44, 2'b00);
      flush = 1'b0;
      check("flush_kept_valid", {31'd0, resp_valid}, 32'd1);
      check("flush_kept_pc", resp_pc, 32'h44);
      drain();

      // reset with a full queue
      resp_ready = 1'b0;
      fetch_chk(32'h30, 2'b00);
      fetch_chk(32'h34, 2'b00);
      step();
      rst = 1'b1;
      sb.delete();
      step();
      check("midrst_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst_ready", {31'd0, req_ready}, 32'd0);
      rst = 1'b0;
      step();
      check("postrst_valid", {31'd0, resp_valid}, 32'd0);
      resp_ready = 1'b1;
      fetch_chk(32'h0, 2'b00);
      drain();

`ifdef IMEM_WRITE_PORT_EN
      // read-first on same-word write, then byte-lane merge, then ignored misaligned write
      resp_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hDEAD_BEEF; wr_strb = 4'b0011;
      fetch_chk(32'h20, 2'b00);
      wr_en = 1'b0;
      img[8] = {img[8][31:16], 16'hBEEF};
      fetch_chk(32'h20, 2'b00);
      wr_en = 1'b1; wr_addr = 32'h22; wr_data = 32'h0; wr_strb = 4'hF;
      step();
      wr_en = 1'b0;
      fetch_chk(32'h20, 2'b00);
      drain();
`endif

      step();
      check("idle_valid", {31'd0, resp_valid}, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
